// File: rtl/node_resolver.sv
// node_resolver: clocked resolution of one NMOS switch-level node.
// Resolves the strongest of N_DRV driver terminals. When undriven, the node
// holds stored gate charge, which may leak to floating. It also reports when
// the node value has settled.

`ifndef NODE_RESOLVER_DEFS
`define NODE_RESOLVER_DEFS
`define W        4
`define B_LEVEL  0
`define S_OFF    3'b000
`define S_PULLUP 3'b011
`define S_STRONG 3'b110
`define L_LO     1'b0
`define L_HI     1'b1
`endif

module node_resolver #(
  parameter int unsigned N_DRV           = 4,
  parameter logic [2:0]  CHARGE_STRENGTH = 3'b001,
  parameter int unsigned DECAY_CYCLES    = 0,
  parameter int unsigned SETTLE_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_DRV*`W-1:0] drv_in,
  output logic [`W-1:0]       node_out,
  output logic                level,
  output logic                floating,
  output logic                contention,
  output logic                settled
);

  localparam int unsigned DW = (DECAY_CYCLES == 0) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [DW-1:0] DECAY_LIM  = DW'(DECAY_CYCLES);
  localparam logic [3:0]    SETTLE_LIM = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_FLOAT,
    ST_DRIVEN,
    ST_HELD
  } state_e;

  state_e          state_q, state_d;
  logic [`W-1:0]   node_q, node_d;
  logic            stored_q, stored_d;
  logic [DW-1:0]   decay_q, decay_d;
  logic            float_q, float_d;
  logic            cont_q, cont_d;
  logic [3:0]      stable_q, stable_d;
  logic            settled_q, settled_d;

  logic [2:0]      smax;
  logic            any_hi;
  logic            any_lo;
  logic            drive_present;
  logic            res_level;
  logic            res_cont;

  // Strongest strength on the node and the levels driven at that strength.
  always_comb begin
    smax   = `S_OFF;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int unsigned i = 0; i < N_DRV; i++) begin
      if (drv_in[i*`W+1 +: 3] > smax) smax = drv_in[i*`W+1 +: 3];
    end
    for (int unsigned i = 0; i < N_DRV; i++) begin
      if (drv_in[i*`W+1 +: 3] == smax) begin
        if (drv_in[i*`W+`B_LEVEL]) any_hi = 1'b1;
        else                       any_lo = 1'b1;
      end
    end
    drive_present = (smax != `S_OFF);
    // Disagreement at the top strength resolves low (pulldown wins).
    res_level     = any_hi & ~any_lo;
    res_cont      = any_hi & any_lo;
  end

  // Next-state logic: a present driver takes precedence over hold/decay.
  always_comb begin
    state_d  = state_q;
    node_d   = node_q;
    stored_d = stored_q;
    decay_d  = decay_q;
    float_d  = float_q;
    cont_d   = 1'b0;
    if (drive_present) begin
      state_d  = ST_DRIVEN;
      node_d   = {smax, res_level};
      stored_d = res_level;
      decay_d  = '0;
      float_d  = 1'b0;
      cont_d   = res_cont;
    end else begin
      unique case (state_q)
        ST_DRIVEN: begin
          state_d = ST_HELD;
          node_d  = {CHARGE_STRENGTH, stored_q};
          float_d = 1'b0;
          if (decay_q != '1) decay_d = decay_q + 1'b1;
        end
        ST_HELD: begin
          if ((DECAY_CYCLES != 0) && (decay_q == DECAY_LIM)) begin
            state_d  = ST_FLOAT;
            node_d   = {`S_OFF, `L_LO};
            float_d  = 1'b1;
            stored_d = `L_LO;
          end else begin
            node_d  = {CHARGE_STRENGTH, stored_q};
            float_d = 1'b0;
            if (decay_q != '1) decay_d = decay_q + 1'b1;
          end
        end
        default: begin
          state_d  = ST_FLOAT;
          node_d   = {`S_OFF, `L_LO};
          float_d  = 1'b1;
          stored_d = `L_LO;
        end
      endcase
    end
  end

  // Settle tracking, based on whether node_out is about to change.
  always_comb begin
    if (node_d != node_q)          stable_d = '0;
    else if (stable_q >= SETTLE_LIM) stable_d = SETTLE_LIM;
    else                           stable_d = stable_q + 4'd1;
    settled_d = (stable_d == SETTLE_LIM);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FLOAT;
      node_q    <= {`S_OFF, `L_LO};
      stored_q  <= `L_LO;
      decay_q   <= '0;
      float_q   <= 1'b1;
      cont_q    <= 1'b0;
      stable_q  <= '0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      node_q    <= node_d;
      stored_q  <= stored_d;
      decay_q   <= decay_d;
      float_q   <= float_d;
      cont_q    <= cont_d;
      stable_q  <= stable_d;
      settled_q <= settled_d;
    end
  end

  assign node_out   = node_q;
  assign level      = node_q[`B_LEVEL];
  assign floating   = float_q;
  assign contention = cont_q;
  assign settled    = settled_q;

endmodule
